apb_master_bridge: RTL and testbench

//  Single-outstanding APB master. Sits directly upstream of the APB RAM slave.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_master_bridge.sv | 151 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB type and width definitions for the master bridge and RAM slave.
package apb_pkg;

  // Master FSM states; the names line up with the slave's state enum.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

  localparam int APB_ADDR_WD = 8;
  localparam int APB_DATA_WD = 32;

endpackage : apb_pkg

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: valid/ready command in, APB SETUP/ACCESS out,
// valid/ready response back. Optional ACCESS timeout enabled with the macro
// APB_MASTER_TIMEOUT_EN (abort after TIMEOUT_CYC wait cycles).
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WD     = APB_ADDR_WD,
  parameter int DATA_WD     = APB_DATA_WD,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_WD-1:0] cmd_addr,
  input  logic [DATA_WD-1:0] cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_WD-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [ADDR_WD-1:0] PADDR,
  output logic [DATA_WD-1:0] PWDATA,
  input  logic [DATA_WD-1:0] PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  apb_mst_state_t     state_reg, state_next;
  logic               accept;
  logic               complete;
  logic               timeout_hit;
  logic               pwrite_reg;
  logic [ADDR_WD-1:0] paddr_reg;
  logic [DATA_WD-1:0] pwdata_reg;
  logic [DATA_WD-1:0] rsp_rdata_reg;
  logic               rsp_err_reg;

  // A timeout of zero cycles is meaningless; this block only exists to make
  // a bad parameter visible in the elaborated hierarchy.
  if (TIMEOUT_CYC < 1) begin : g_timeout_cyc_invalid
  end

  // State register; an async reset drops PSEL/PENABLE at once and discards
  // any in-flight command.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode plus the single-cycle accept/complete strobes.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          complete   = 1'b1;
          state_next = RESP;
        end else if (timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command latch and response capture; PADDR/PWRITE/PWDATA only change on
  // accept so they hold their last values between transfers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        pwrite_reg <= cmd_write;
        paddr_reg  <= cmd_addr;
        pwdata_reg <= cmd_write ? cmd_wdata : '0;
      end
      if (complete) begin
        rsp_rdata_reg <= pwrite_reg ? '0 : PRDATA;
        rsp_err_reg   <= PSLVERR;
      end else if (timeout_hit) begin
        rsp_rdata_reg <= '0;
        rsp_err_reg   <= 1'b1;
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_reg;

  // Counts ACCESS wait cycles; restarted for every new command.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      to_cnt_reg <= '0;
    end else if (accept) begin
      to_cnt_reg <= '0;
    end else if ((state_reg == ACCESS) && !PREADY) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  // Abort on the wait cycle that brings the count to TIMEOUT_CYC, so ACCESS
  // lasts exactly TIMEOUT_CYC cycles; PREADY in that cycle still wins.
  assign timeout_hit = (state_reg == ACCESS) && !PREADY &&
                       (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Moore-decoded handshake and APB control outputs.
  assign cmd_ready = (state_reg == IDLE) && PRESETn;
  assign rsp_valid = (state_reg == RESP);
  assign PSEL      = (state_reg == SETUP) || (state_reg == ACCESS);
  assign PENABLE   = (state_reg == ACCESS);
  assign PWRITE    = pwrite_reg;
  assign PADDR     = paddr_reg;
  assign PWDATA    = pwdata_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule : apb_master_bridge

// File: tb/tb_apb_master_bridge.sv
// Directed testbench for apb_master_bridge with a small behavioural APB RAM
// slave (programmable wait states, error and stuck-PREADY modes).
module tb_apb_master_bridge;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .ADDR_WD(AW), .DATA_WD(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Behavioural slave
  logic [DW-1:0] mem [256];
  int   wait_cfg = 0;
  int   wait_cnt = 0;
  logic err_cfg  = 1'b0;
  logic stuck    = 1'b0;

  assign PREADY  = PSEL && PENABLE && !stuck && (wait_cnt >= wait_cfg);
  assign PRDATA  = mem[PADDR];
  assign PSLVERR = err_cfg && PREADY;

  always @(posedge PCLK) begin
    if (!PRESETn) begin
      wait_cnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (PSEL && PENABLE && !PREADY) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
      if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
    end
  end

  // Drive a command at the current negedge, hold it until accepted, and
  // return at the negedge of the SETUP cycle with cmd_valid dropped.
  task automatic issue(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge PCLK);
    end
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  // Wait for rsp_valid (bounded), counting ACCESS cycles on the way.
  task automatic wait_rsp(output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      if (PSEL && PENABLE) n++;
      @(negedge PCLK);
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, cmd_ready} !== '0)
      begin errors++; $display("FAIL reset_outputs: psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h rv=%b rdata=%h err=%b crdy=%b, required all 0",
        PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, cmd_ready); end
    PRESETn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
    @(negedge PCLK);
    $display("test_reset done");
  endtask

  task automatic test_write_zero_wait();
    bit ok;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_idle_ready: got %b want 1", cmd_ready); end
    issue(1'b1, 8'h10, 32'hDEADBEEF, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_accept: got no accept want accept"); end
    checks++;
    if ({PSEL, PENABLE, rsp_valid, PWRITE, PADDR, PWDATA} !== {4'b1001, 8'h10, 32'hDEADBEEF})
      begin errors++; $display("FAIL wr_setup: psel=%b pen=%b rv=%b pwrite=%b paddr=%h pwdata=%h, want 1 0 0 1 10 deadbeef",
        PSEL, PENABLE, rsp_valid, PWRITE, PADDR, PWDATA); end
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b110)
      begin errors++; $display("FAIL wr_access: psel/pen/rv=%b%b%b want 110", PSEL, PENABLE, rsp_valid); end
    @(negedge PCLK);
    checks++;
    if ({rsp_valid, PSEL, PENABLE, cmd_ready, rsp_err, rsp_rdata} !== {5'b10000, 32'h0})
      begin errors++; $display("FAIL wr_resp: rv=%b psel=%b pen=%b crdy=%b err=%b rdata=%h, want 1 0 0 0 0 0",
        rsp_valid, PSEL, PENABLE, cmd_ready, rsp_err, rsp_rdata); end
    finish_rsp();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01)
      begin errors++; $display("FAIL wr_after_hs: rv/crdy=%b%b want 01", rsp_valid, cmd_ready); end
    $display("test_write_zero_wait done");
  endtask

  task automatic test_read();
    bit ok; int n;
    issue(1'b0, 8'h10, 32'h12345678, ok);
    checks++;
    if ({ok, PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {4'b1100, 8'h10, 32'h0})
      begin errors++; $display("FAIL rd_setup: ok=%b psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h, want 1 1 0 0 10 0",
        ok, PSEL, PENABLE, PWRITE, PADDR, PWDATA); end
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PADDR} !== {2'b11, 8'h10})
      begin errors++; $display("FAIL rd_access_addr: psel=%b pen=%b paddr=%h want 1 1 10", PSEL, PENABLE, PADDR); end
    wait_rsp(n, ok);
    checks++;
    if ({ok, rsp_err, rsp_rdata} !== {2'b10, 32'hDEADBEEF})
      begin errors++; $display("FAIL rd_resp: ok=%b err=%b rdata=%h want 1 0 deadbeef", ok, rsp_err, rsp_rdata); end
    finish_rsp();
    $display("test_read done");
  endtask

  task automatic test_wait_err();
    bit ok; int n;
    wait_cfg = 3; err_cfg = 1'b1;
    issue(1'b0, 8'h20, 32'h0, ok);
    wait_rsp(n, ok);
    checks++;
    if (!ok || n != 4 || rsp_err !== 1'b1)
      begin errors++; $display("FAIL wait_err: ok=%b access_cycles=%0d err=%b want 1 4 1", ok, n, rsp_err); end
    finish_rsp();
    wait_cfg = 0; err_cfg = 1'b0;
    $display("test_wait_err done");
  endtask

  task automatic test_rsp_backpressure();
    bit ok; int n;
    issue(1'b0, 8'h10, 32'h0, ok);
    wait_rsp(n, ok);
    cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 32'h0BADF00D; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({ok, rsp_valid, cmd_ready, PSEL, rsp_err, rsp_rdata} !== {5'b11000, 32'hDEADBEEF})
        begin errors++; $display("FAIL bp_hold[%0d]: ok=%b rv=%b crdy=%b psel=%b err=%b rdata=%h want 1 1 0 0 0 deadbeef",
          i, ok, rsp_valid, cmd_ready, PSEL, rsp_err, rsp_rdata); end
      if (i == 4) rsp_ready = 1'b1;
      @(negedge PCLK);
    end
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, PSEL} !== 3'b010)
      begin errors++; $display("FAIL bp_release: rv/crdy/psel=%b%b%b want 010", rsp_valid, cmd_ready, PSEL); end
    @(negedge PCLK);
    cmd_valid = 1'b0;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b101, 8'h30})
      begin errors++; $display("FAIL bp_next_setup: psel=%b pen=%b pwrite=%b paddr=%h want 1 0 1 30", PSEL, PENABLE, PWRITE, PADDR); end
    wait_rsp(n, ok);
    finish_rsp();
    $display("test_rsp_backpressure done");
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_cfg = 5;
    issue(1'b0, 8'h40, 32'h0, ok);
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin errors++; $display("FAIL rst_mid_access: psel/pen=%b%b want 11", PSEL, PENABLE); end
    #1 PRESETn = 1'b0;
    #1;
    checks++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0000)
      begin errors++; $display("FAIL rst_mid_drop: psel=%b pen=%b rv=%b crdy=%b want 0000", PSEL, PENABLE, rsp_valid, cmd_ready); end
    @(negedge PCLK);
    PRESETn = 1'b1;
    wait_cfg = 0;
    @(posedge PCLK);
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, PSEL} !== 3'b100)
      begin errors++; $display("FAIL rst_mid_release: crdy=%b rv=%b psel=%b want 1 0 0", cmd_ready, rsp_valid, PSEL); end
    @(negedge PCLK);
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    bit ok; int n;
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h50;
    for (int k = 0; k < 12; k++) begin
      if (k % 4 == 0) cmd_wdata = 32'h1000 + k;
      checks++;
      if ({cmd_ready, PSEL, PENABLE, rsp_valid} !==
          {k % 4 == 0, (k % 4 == 1) || (k % 4 == 2), k % 4 == 2, k % 4 == 3})
        begin errors++; $display("FAIL b2b[%0d]: crdy/psel/pen/rv=%b%b%b%b", k, cmd_ready, PSEL, PENABLE, rsp_valid); end
      @(negedge PCLK);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    issue(1'b0, 8'h50, 32'h0, ok);
    wait_rsp(n, ok);
    checks++;
    if ({ok, rsp_rdata} !== {1'b1, 32'h00001008})
      begin errors++; $display("FAIL b2b_readback: ok=%b rdata=%h want 1 00001008", ok, rsp_rdata); end
    finish_rsp();
    $display("test_back_to_back done");
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int n;
    stuck = 1'b1;
    issue(1'b0, 8'h50, 32'h0, ok);
    wait_rsp(n, ok);
    checks++;
    if (!ok || n != TO || rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
      begin errors++; $display("FAIL timeout: ok=%b access_cycles=%0d err=%b rdata=%h want 1 %0d 1 0", ok, n, rsp_err, rsp_rdata, TO); end
    stuck = 1'b0;
    finish_rsp();
    $display("test_timeout done");
  endtask
`endif

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read();
    test_wait_err();
    test_rsp_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_apb_master_bridge
